// File: rtl/nts_tx_header_writer_pkg.sv
// nts_tx_header_writer_pkg: shared constants and writer state encoding for the NTS TX header path
package nts_tx_header_writer_pkg;
   localparam int NTP_HEADER_BLOCKS = 6;
   localparam int NTP_HEADER_BYTES = 48;
   localparam logic [7:0] MASK_ALL = 8'hFF;
   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN, S_DONE, S_ERR} wr_state_t;
endpackage

// File: rtl/nts_byte_realign.sv
// nts_byte_realign: shifts a header block into buffer-word alignment and merges the previous carry bytes
module nts_byte_realign
   import nts_tx_header_writer_pkg::*;
(
   input  logic [63:0] i_carry,
   input  logic [63:0] i_block,
   input  logic [2:0]  i_ofs,
   input  logic        i_first,
   input  logic        i_flush,
   output logic [63:0] o_data,
   output logic [63:0] o_carry,
   output logic [7:0]  o_mask
);
   logic [5:0]  w_sh;
   logic [63:0] w_blk;
   logic [7:0]  w_first_mask;
   assign w_sh = {i_ofs, 3'b000};
   assign w_blk = i_flush ? 64'd0 : i_block;
   // a shift of 64 yields zero, so offset 0 drops the carry entirely
   assign o_data = (i_carry << (7'd64 - {1'b0, w_sh})) | (w_blk >> w_sh);
   assign o_carry = i_block & ~(64'hFFFF_FFFF_FFFF_FFFF << w_sh);
   assign w_first_mask = MASK_ALL >> i_ofs;
   assign o_mask = i_flush ? ~w_first_mask : i_first ? w_first_mask : MASK_ALL;
endmodule

// File: rtl/nts_tx_header_writer.sv
// nts_tx_header_writer: drains six NTP header blocks and writes them byte-aligned into the TX buffer
module nts_tx_header_writer
   import nts_tx_header_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_areset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_start_word_addr,
   input  logic [2:0]            i_start_byte_ofs,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   input  logic                  i_tx_empty,
   output logic                  o_tx_read,
   input  logic [2:0]            i_tx_header_block,
   input  logic [63:0]           i_tx_header_data,
   output logic                  o_buf_write_en,
   input  logic                  i_buf_ready,
   output logic [ADDR_WIDTH-1:0] o_buf_address,
   output logic [63:0]           o_buf_write_data,
   output logic [7:0]            o_buf_write_mask
);
   wr_state_t             r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_ofs, r_idx;
   logic [63:0]           r_carry, r_data;
   logic [7:0]            r_mask;
   logic                  r_en;
   logic                  w_free, w_accept, w_avail, w_match, w_read, w_seq_err, w_load, w_last;
   logic [63:0]           w_data, w_carry;
   logic [7:0]            w_mask;

   assign w_free = !r_en || i_buf_ready;
   assign w_accept = r_en && i_buf_ready;
   assign w_avail = (r_state == S_STREAM) && !i_tx_empty;
   assign w_match = i_tx_header_block == r_idx;
   assign w_read = w_avail && w_match && w_free;
   assign w_seq_err = w_avail && !w_match;
   assign w_load = w_read || ((r_state == S_FLUSH) && w_free);
   assign w_last = r_idx == 3'(NTP_HEADER_BLOCKS - 1);

   nts_byte_realign u_realign (
      .i_carry (r_carry),
      .i_block (i_tx_header_data),
      .i_ofs   (r_ofs),
      .i_first (r_idx == 3'd0),
      .i_flush (r_state == S_FLUSH),
      .o_data  (w_data),
      .o_carry (w_carry),
      .o_mask  (w_mask)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = i_start ? S_STREAM : S_IDLE;
         S_STREAM: w_next = w_seq_err ? S_ERR : (w_read && w_last) ? ((r_ofs != 3'd0) ? S_FLUSH : S_DRAIN) : S_STREAM;
         S_FLUSH:  w_next = w_free ? S_DRAIN : S_FLUSH;
         // DRAIN waits for the final word to be accepted so done follows the last write
         S_DRAIN:  w_next = w_free ? S_DONE : S_DRAIN;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_ofs   <= '0;
         r_idx   <= '0;
         r_carry <= '0;
         r_data  <= '0;
         r_mask  <= '0;
         r_en    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && i_start) begin
            r_addr  <= i_start_word_addr;
            r_ofs   <= i_start_byte_ofs;
            r_idx   <= '0;
            r_carry <= '0;
         end
         if (w_read) begin
            r_idx   <= r_idx + 3'd1;
            r_carry <= w_carry;
         end
         if (w_accept) r_addr <= r_addr + ADDR_WIDTH'(1);
         if (w_seq_err) r_en <= 1'b0;
         else if (w_load) begin
            r_en   <= 1'b1;
            r_data <= w_data;
            r_mask <= w_mask;
         end else if (w_accept) r_en <= 1'b0;
      end
   end

   assign o_busy = (r_state == S_STREAM) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
   assign o_done = r_state == S_DONE;
   assign o_error = r_state == S_ERR;
   assign o_tx_read = w_read;
   assign o_buf_write_en = r_en;
   assign o_buf_address = r_addr;
   assign o_buf_write_data = r_data;
   assign o_buf_write_mask = r_mask;
endmodule

// File: doc/nts_tx_header_writer.md
Name: nts_tx_header_writer

Overview:
- Downstream consumer of the NTP timestamp/header stage.
- Drains the six 64-bit NTP header blocks (48 bytes) from the header stage's empty/read interface.
- Writes them into the TX packet buffer at a byte-granular position, realigning them to 64-bit buffer words with byte-lane masks.
- Started by TX control once the Ethernet/IP/UDP headers are placed. A typical position is byte 42, which gives byte offset 2.

Parameters:
- ADDR_WIDTH, 8, TX buffer word-address width (64-bit words).

Ports:
- i_clk  in  1  system clock
- i_areset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle start pulse; ignored while o_busy=1
- i_start_word_addr  in  ADDR_WIDTH  buffer word address of header byte 0; sampled on accepted i_start
- i_start_byte_ofs  in  3  byte lane (0..7) of header byte 0 within that word; sampled on accepted i_start
- o_busy  out  1  high from the cycle after start until completion
- o_done  out  1  one-cycle pulse on successful completion
- o_error  out  1  one-cycle pulse on block sequence error
- i_tx_empty  in  1  header stage has no block available
- o_tx_read  out  1  consume the current header block
- i_tx_header_block  in  3  index (0..5) of the presented block
- i_tx_header_data  in  64  presented block, big-endian (byte 0 = bits 63:56)
- o_buf_write_en  out  1  write request to TX buffer
- i_buf_ready  in  1  buffer accepts the write this cycle
- o_buf_address  out  ADDR_WIDTH  word address of the write
- o_buf_write_data  out  64  write data
- o_buf_write_mask  out  8  byte-lane enables; bit 7 = bits 63:56

Behaviour:
- Reset: all outputs 0, state IDLE, carry register 0, expected block index 0.
- States and transitions:
  - IDLE: on i_start, latch address and offset, set expected index to 0, go to STREAM.
  - STREAM: consume blocks 0..5 in order; after block 5 go to FLUSH if offset≠0, else to DONE.
  - FLUSH: write the carry word.
  - DONE: pulse o_done, return to IDLE.
  - ERR: pulse o_error, return to IDLE.
- Output handshake: valid/ready. A write transfers when o_buf_write_en=1 and i_buf_ready=1. Address, data and mask are registered and held stable while en=1 and ready=0.
- o_tx_read (combinational) = STREAM & !i_tx_empty & index match & (!o_buf_write_en | i_buf_ready). When it is high, the output register loads the next word in the same edge.
- Realignment, with offset k and block b:
  - Output word = {carry[8k bytes], b >> 8k}.
  - New carry = low k bytes of b.
  - Block 0 mask = 8'hFF >> k; blocks 1..5 mask = 8'hFF.
  - FLUSH data = {carry, zeros}; FLUSH mask = ~(8'hFF >> k).
- Address starts at i_start_word_addr and increments after each accepted write, wrapping modulo 2^ADDR_WIDTH.
- Write count and latency:
  - Offset 0: 6 writes. Offset ≠0: 7 writes.
  - Back-to-back throughput: one word per cycle.
  - First o_buf_write_en no earlier than 2 cycles after i_start.
- Completion: o_done pulses the cycle after the last accepted write; o_busy falls in the same cycle.
- Sequence error: if !i_tx_empty and i_tx_header_block ≠ expected index in STREAM:
  - Do not read; drop any pending write (en→0).
  - Go to ERR; the header stage is cleared externally.
- i_start while busy: ignored, with no effect on the current transfer.
- Empty mid-stream: wait in STREAM indefinitely. A pending write still completes.
- Reset mid-operation: asynchronous return to reset values; no partial write is held.

Decomposition:
- Shared NTS TX package:
  - NTP_HEADER_BLOCKS = 6
  - NTP_HEADER_BYTES = 48
  - writer state encoding
  - mask helper constant 8'hFF
- Sub-module nts_byte_realign:
  - combinational shift/merge of {carry, block} by k
  - carry-out
  - mask generation for first, middle and flush words

Test Plan:
- Offset 0, addr 8'h10, blocks 0..5 with block0=64'h040100001007de1a, block1=64'h1007d155abad1dea, i_buf_ready=1 → 6 writes at 10..15, mask FF, data equal to the blocks; o_done 1 cycle after last write.
- Offset 2, addr 8'h05, same blocks → write0 addr 05 data 64'h0000040100001007 mask 3F; write1 addr 06 data 64'hde1a1007d155abad mask FF; write6 addr 0B data {block5[15:0],48'h0} mask C0; 7 writes total.
- Offset 2, i_buf_ready low for 3 cycles on write1 → address/data/mask held stable, o_tx_read stays 0; sequence then completes with identical data.
- Start at addr 8'hFE, offset 0 → addresses FE, FF, 00, 01, 02, 03.
- Block index 3 presented when 2 expected → no o_tx_read; o_error pulses once; o_busy falls; no further writes.
- i_areset asserted after 3 writes → all outputs 0 immediately; a new i_start afterwards completes normally.
